// File: rtl/rast_sample_iter_ctrl_if.sv
// Handshake bundle around the sample iterator: triangle/box in from bbox, samples out to hash.
// master = the iterator controller, slave = the surrounding pipeline (bbox + hash stages).
interface rast_sample_iter_ctrl_if #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
);
  logic                          tri_valid;
  logic                          tri_ready;
  logic [VERTS*AXIS*SIGFIG-1:0]  tri_in;
  logic [COLORS*SIGFIG-1:0]      color_in;
  logic [2*SIGFIG-1:0]           box_ll;
  logic [2*SIGFIG-1:0]           box_ur;
  logic [3:0]                    subsample;
  logic                          samp_valid;
  logic                          samp_ready;
  logic [2*SIGFIG-1:0]           samp_pos;
  logic [VERTS*AXIS*SIGFIG-1:0]  samp_tri;
  logic [COLORS*SIGFIG-1:0]      samp_color;
  logic                          samp_last;

  modport master (
    input  tri_valid, tri_in, color_in, box_ll, box_ur, subsample, samp_ready,
    output tri_ready, samp_valid, samp_pos, samp_tri, samp_color, samp_last
  );
  modport slave (
    output tri_valid, tri_in, color_in, box_ll, box_ur, subsample, samp_ready,
    input  tri_ready, samp_valid, samp_pos, samp_tri, samp_color, samp_last
  );
endinterface

// File: rtl/rast_sample_iter_ctrl.sv
// Walks one micropolygon bounding box in raster order at the MSAA sample pitch.
// Optional RAST_ITER_STATS_EN adds saturating triangle/sample counters.
module rast_sample_iter_ctrl #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rast_sample_iter_ctrl_if.master  bus
`ifdef RAST_ITER_STATS_EN
  ,
  output logic [31:0]              stat_tris,
  output logic [31:0]              stat_samples
`endif
);

  typedef logic signed [SIGFIG-1:0] crd_t;
  typedef logic signed [SIGFIG:0]   wcrd_t;
  typedef enum logic {IDLE = 1'b0, TEST = 1'b1} state_t;
  typedef struct packed {
    crd_t ll_x;
    crd_t ur_x;
    crd_t ur_y;
    crd_t step;
  } box_t;

  localparam crd_t PIX = crd_t'(1) << RADIX;

  state_t                       state_q, state_d;
  box_t                         box_q, box_d;
  crd_t                         x_q, x_d, y_q, y_d;
  logic                         last_q, last_d;
  logic [VERTS*AXIS*SIGFIG-1:0] tri_q, tri_d;
  logic [COLORS*SIGFIG-1:0]     color_q, color_d;

  logic accept, adv, illegal;
  crd_t step_in, in_ll_x, in_ll_y, in_ur_x, in_ur_y;

  // One extra bit so the step past the largest coordinate cannot wrap negative.
  function automatic logic over(input crd_t c, input crd_t s, input crd_t lim);
    wcrd_t sum;
    sum = wcrd_t'({c[SIGFIG-1], c}) + wcrd_t'({s[SIGFIG-1], s});
    return sum > wcrd_t'({lim[SIGFIG-1], lim});
  endfunction

  assign in_ll_x = crd_t'(bus.box_ll[SIGFIG-1:0]);
  assign in_ll_y = crd_t'(bus.box_ll[2*SIGFIG-1:SIGFIG]);
  assign in_ur_x = crd_t'(bus.box_ur[SIGFIG-1:0]);
  assign in_ur_y = crd_t'(bus.box_ur[2*SIGFIG-1:SIGFIG]);
  assign illegal = (in_ur_x < in_ll_x) | (in_ur_y < in_ll_y);

  always_comb begin
    case (bus.subsample)
      4'b0100: step_in = PIX >> 1;
      4'b0010: step_in = PIX >> 2;
      4'b0001: step_in = PIX >> 3;
      default: step_in = PIX;
    endcase
  end

  assign bus.samp_valid = (state_q == TEST);
  assign adv            = bus.samp_valid & bus.samp_ready;
  assign bus.tri_ready  = (state_q == IDLE) | (adv & last_q);
  assign accept         = bus.tri_valid & bus.tri_ready;

  assign bus.samp_pos   = {y_q, x_q};
  assign bus.samp_last  = last_q;
  assign bus.samp_tri   = tri_q;
  assign bus.samp_color = color_q;

  always_comb begin
    state_d = state_q;
    box_d   = box_q;
    x_d     = x_q;
    y_d     = y_q;
    last_d  = last_q;
    tri_d   = tri_q;
    color_d = color_q;
    if (accept) begin
      // A new box takes priority; it may replace the final sample of the previous one.
      state_d    = TEST;
      box_d.ll_x = in_ll_x;
      box_d.ur_x = in_ur_x;
      box_d.ur_y = in_ur_y;
      box_d.step = step_in;
      x_d        = in_ll_x;
      y_d        = in_ll_y;
      last_d     = illegal | (over(in_ll_x, step_in, in_ur_x) & over(in_ll_y, step_in, in_ur_y));
      tri_d      = bus.tri_in;
      color_d    = bus.color_in;
    end else if (adv) begin
      if (last_q) begin
        state_d = IDLE;
        last_d  = 1'b0;
      end else begin
        if (over(x_q, box_q.step, box_q.ur_x)) begin
          x_d = box_q.ll_x;
          y_d = y_q + box_q.step;
        end else begin
          x_d = x_q + box_q.step;
        end
        last_d = over(x_d, box_q.step, box_q.ur_x) & over(y_d, box_q.step, box_q.ur_y);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      box_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      last_q  <= 1'b0;
      tri_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      box_q   <= box_d;
      x_q     <= x_d;
      y_q     <= y_d;
      last_q  <= last_d;
      tri_q   <= tri_d;
      color_q <= color_d;
    end
  end

`ifdef RAST_ITER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_tris    <= '0;
      stat_samples <= '0;
    end else begin
      if (accept && stat_tris != '1)
        stat_tris <= stat_tris + 32'd1;
      if (adv && stat_samples != '1)
        stat_samples <= stat_samples + 32'd1;
    end
  end
`endif

endmodule
